// File: rtl/serial_adder_pkg.sv
// Shared state and mode encodings for the bit-serial add/subtract engine.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_unit_digit_adder_chain.sv
// DIGIT-stage ripple chain of 1-bit full adders; also exposes the carry into the top stage.
module digit_adder_chain #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_top_o
);

    logic [DIGIT:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o     = c[DIGIT];
    assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract engine, DIGIT bits per cycle, WIDTH/DIGIT cycles per operation.
// Define SERIAL_ADDER_OVERFLOW_EN to build the signed-overflow flag; otherwise oOverflow is 0.
module serial_adder_unit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iSubtract,
    input  logic [WIDTH-1:0] iData_A,
    input  logic [WIDTH-1:0] iData_B,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic             oCarry,
    output logic             oOverflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cy_q, cy_d;

    logic [DIGIT-1:0] sum_digit;
    logic             chain_cout, chain_ctop;
    logic [WIDTH-1:0] sr_shift;
    logic             accept, last_step;

    digit_adder_chain #(.DIGIT(DIGIT)) u_chain (
        .a_i     (sa_q[DIGIT-1:0]),
        .b_i     (sb_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (sum_digit),
        .c_o     (chain_cout),
        .c_top_o (chain_ctop)
    );

    assign accept    = iStart && (state_q != RUN);
    assign last_step = (state_q == RUN) && (cnt_q == CW'(N - 1));
    // New digit enters at the MSB end so the LSB digit lands at bit 0 after N steps.
    assign sr_shift  = (sr_q >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = iStart ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state_q == RUN);
        oDone = (state_q == DONE);
    end

    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cy_d    = cy_q;
        if (accept) begin
            sa_d    = iData_A;
            sb_d    = (iSubtract == MODE_SUB) ? ~iData_B : iData_B;
            sr_d    = '0;
            carry_d = iSubtract;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sa_d    = sa_q >> DIGIT;
            sb_d    = sb_q >> DIGIT;
            sr_d    = sr_shift;
            carry_d = chain_cout;
            cnt_d   = cnt_q + CW'(1);
        end
        if (last_step) begin
            res_d = sr_shift;
            cy_d  = chain_cout;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
        end
    end

    assign oResult = res_q;
    assign oCarry  = cy_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (last_step) ovf_d = chain_ctop ^ chain_cout;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign oOverflow = ovf_q;
`else
    wire unused_chain_ctop = chain_ctop;
    assign oOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench: DIGIT=1 and DIGIT=4 instances, directed table, corner sequences, random vs model.
module tb_serial_adder_unit;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub_in, sel;
    logic [15:0] a_in, b_in;

    logic        busy1, done1, cy1, ov1, busy4, done4, cy4, ov4;
    logic [15:0] res1, res4;
    logic        busy_s, done_s, cy_s, ov_s;
    logic [15:0] res_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .Clock(clk), .Reset(rst), .iStart(start & ~sel), .iSubtract(sub_in),
        .iData_A(a_in), .iData_B(b_in), .oBusy(busy1), .oDone(done1),
        .oResult(res1), .oCarry(cy1), .oOverflow(ov1)
    );

    serial_adder_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .Clock(clk), .Reset(rst), .iStart(start & sel), .iSubtract(sub_in),
        .iData_A(a_in), .iData_B(b_in), .oBusy(busy4), .oDone(done4),
        .oResult(res4), .oCarry(cy4), .oOverflow(ov4)
    );

    assign busy_s = sel ? busy4 : busy1;
    assign done_s = sel ? done4 : done1;
    assign res_s  = sel ? res4  : res1;
    assign cy_s   = sel ? cy4   : cy1;
    assign ov_s   = sel ? ov4   : ov1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int u, exact;
        logic v;
        u     = sub ? (int'(a) - int'(b) + 65536) : (int'(a) + int'(b));
        exact = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        v     = OV_EN && (exact > 32767 || exact < -32768);
        return {u[16], v, u[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] er, input logic ec, input logic ev);
        int n;
        n = sel ? 4 : 16;
        a_in = a; b_in = b; sub_in = sub; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); sub_in = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            check("busy_run", {30'd0, busy_s, done_s}, 32'b10);
            tick();
        end
        check("done_pulse", {30'd0, busy_s, done_s}, 32'b01);
        check("result", {16'd0, res_s}, {16'd0, er});
        check("carry", {31'd0, cy_s}, {31'd0, ec});
        check("overflow", {31'd0, ov_s}, {31'd0, ev});
        tick();
        check("idle_after", {30'd0, busy_s, done_s}, 32'b00);
    endtask

    initial begin
        logic [17:0] m;
        logic        found;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OV_EN};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OV_EN};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub_in = 1'b0; sel = 1'b0; a_in = '0; b_in = '0;
        #1;
        check("reset_d1", {12'd0, busy1, done1, res1, cy1, ov1}, 32'd0);
        check("reset_d4", {12'd0, busy4, done4, res4, cy4, ov4}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 6; i++)
                run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].r, tbl[i].c, tbl[i].v);
        end

        // iStart during RUN is ignored and not queued
        sel = 1'b0;
        a_in = 16'h1234; b_in = 16'h4321; sub_in = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            start = (i == 3);
            if (i == 3) begin a_in = 16'hFFFF; b_in = 16'hFFFF; sub_in = 1'b1; end
            check("ign_busy", {30'd0, busy_s, done_s}, 32'b10);
            tick();
        end
        start = 1'b0;
        check("ign_done", {30'd0, busy_s, done_s}, 32'b01);
        check("ign_result", {16'd0, res_s}, 32'h5555);
        tick();
        check("ign_not_queued", {30'd0, busy_s, done_s}, 32'b00);

        // Reset in the middle of RUN aborts the operation
        a_in = 16'h0F0F; b_in = 16'h0101; sub_in = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_outputs", {12'd0, busy1, done1, res1, cy1, ov1}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy1 || done1) found = 1'b1;
            tick();
        end
        check("abort_no_done", {31'd0, found}, 32'd0);
        check("abort_result", {16'd0, res1}, 32'd0);

        // Back-to-back on the DIGIT=4 instance: one operation every 5 cycles
        sel = 1'b1;
        a_in = 16'h00FF; b_in = 16'h0F01; sub_in = 1'b0; start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (done_s) found = 1'b1;
        end
        check("b2b_first_done", {31'd0, found}, 32'd1);
        for (int j = 1; j <= 15; j++) begin
            if (j == 15) start = 1'b0;
            tick();
            check("b2b_phase", {30'd0, busy_s, done_s}, (j % 5 == 0) ? 32'b01 : 32'b10);
            if (j % 5 == 0) begin
                check("b2b_result", {16'd0, res_s}, 32'h1000);
                check("b2b_carry", {31'd0, cy_s}, 32'd0);
            end
        end
        start = 1'b0;
        tick();
        check("b2b_stop", {30'd0, busy_s, done_s}, 32'b00);

        // Randomised operations against the arithmetic model
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 30; i++) begin
                logic [15:0] ra, rb;
                logic        rs;
                ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
                if (i % 7 == 0) ra = 16'h7FFF;
                if (i % 11 == 0) rb = 16'h8000;
                m = model(ra, rb, rs);
                run_op(ra, rb, rs, m[15:0], m[17], m[16]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_unit.md
# serial_adder_unit

- Bit-serial add/subtract engine, a parametrised successor to the team's 1-bit full-adder and counter primitives.
- Each cycle it processes DIGIT bits of two WIDTH-bit operands through a ripple chain of 1-bit full adders, and uses a step counter to sequence the operation.
- It completes one operation in WIDTH/DIGIT cycles under a start/busy/done handshake.
- It sits beside the datapath registers wherever area matters more than latency.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits processed per cycle; legal range 1..WIDTH.
- Clock  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- iStart  in  1  request; sampled on a rising edge while not busy.
- iSubtract  in  1  0: A+B; 1: A−B. Sampled together with iStart.
- iData_A  in  WIDTH  operand A, captured on the accepting edge.
- iData_B  in  WIDTH  operand B, captured on the accepting edge.
- oBusy  out  1  high while an operation is in progress.
- oDone  out  1  one-cycle pulse when oResult, oCarry and oOverflow update.
- oResult  out  WIDTH  last completed result, modulo 2^WIDTH.
- oCarry  out  1  carry out of the MSB; for subtraction 1 means no borrow.
- oOverflow  out  1  signed two's-complement overflow (see Configuration).

## Operation
- N = WIDTH/DIGIT steps.
- **States:**
  - IDLE →(iStart) RUN.
  - RUN →(step N done) DONE.
  - DONE →(iStart) RUN.
  - DONE →(no iStart) IDLE.
- **Accept:** iStart is accepted in IDLE or DONE.
  - On acceptance, A is latched into shift register SA.
  - B is latched into SB, inverted when iSubtract=1.
  - The carry register is loaded with iSubtract; step counter = 0.
- **RUN step:**
  - The DIGIT LSBs of SA and SB plus the carry register go through the DIGIT-stage full-adder chain.
  - The sum digit shifts into the MSB end of the internal result shift register SR.
  - SA and SB shift right by DIGIT; the carry register takes the chain carry-out.
  - The counter increments.
- **Completion:** on the edge ending step N:
  - SR (final digit included) is copied to oResult.
  - oCarry takes the final carry; oOverflow is updated.
  - State becomes DONE.
- oResult, oCarry and oOverflow hold their values until the next completion. They never show partial results.
- iStart while in RUN is ignored; no queuing.
- Operand changes after acceptance have no effect.
- **Reset (any time, including mid-RUN):**
  - State returns to IDLE; all registers clear.
  - oBusy=0, oDone=0, oResult=0, oCarry=0, oOverflow=0.
  - An aborted operation produces no oDone.

## Timing
- iStart accepted at edge k:
  - oBusy is 1 after edges k … k+N−1.
  - oDone is 1 for the single cycle after edge k+N; outputs update at edge k+N.
- **Back-to-back:** iStart high during the oDone cycle is accepted at edge k+N+1, giving one operation every N+1 cycles.
- oBusy=0 and oDone=1 in the DONE cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset deassertion is assumed synchronised externally. The first edge after release may sample iStart.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN defined:
  - An extra register captures the carry into the MSB during the final step.
  - oOverflow = carry into MSB XOR carry out of MSB, valid with oDone.
- Not defined:
  - That logic is removed and oOverflow is tied to 0.
  - The port remains present, so instantiations are unchanged.

## Structure
- **Shared package serial_adder_pkg:**
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: MODE_ADD=1'b0, MODE_SUB=1'b1.
- Step-counter width is $clog2(N+1) (minimum 1), derived locally.
- **Sub-module digit_adder_chain:**
  - Parametrised on DIGIT.
  - A generate loop of 1-bit full adders with carry rippled.
  - Exposes the sum digit, carry-out and carry into the top stage; the last feeds overflow on the final step.

## Test plan
- WIDTH=16, DIGIT=1: A=0x1234, B=0x4321, add.
  - oBusy high for 16 cycles; oDone 16 cycles after the accepting edge.
  - oResult=0x5555, oCarry=0, oOverflow=0.
- A=0xFFFF, B=0x0001, add → oResult=0x0000, oCarry=1, oOverflow=0.
- A=0x0005, B=0x0007, subtract → oResult=0xFFFE, oCarry=0 (borrow), oOverflow=0.
- A=0x7FFF, B=0x0001, add → oResult=0x8000, oCarry=0.
  - oOverflow=1 with SERIAL_ADDER_OVERFLOW_EN, 0 without.
- Pulse iStart again at cycle 3 of RUN, then assert Reset at cycle 5.
  - The cycle-3 iStart is ignored.
  - The reset aborts the operation: oBusy=0, oResult=0, no oDone pulse.
- WIDTH=16, DIGIT=4: iStart held high continuously with A=0x00FF, B=0x0F01.
  - oDone every 5 cycles.
  - oResult=0x1000 each time, oCarry=0.
